// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the HI/LO multiply/divide unit.
// Operand magnitudes go through a MAX_W-wide helper, so WIDTH is capped at 64.
package muldiv_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] v,
    input logic             neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_core.sv
// md_iter_core: shared WIDTH-cycle shift datapath.
// Multiplies by add-shift or divides by subtract-restore.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] ql_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ql_q, ql_d;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, sh, df;

  // {acc,ql} is the double-width shift register for both modes
  always_comb begin
    sum   = {1'b0, acc_q} + (ql_q[0] ? {1'b0, m_q} : '0);
    sh    = {acc_q, ql_q[WIDTH-1]};
    df    = sh - {1'b0, m_q};
    acc_d = acc_q;
    ql_d  = ql_q;
    if (div_i) begin
      if (!df[WIDTH]) begin
        acc_d = df[WIDTH-1:0];
        ql_d  = {ql_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = sh[WIDTH-1:0];
        ql_d  = {ql_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[WIDTH:1];
      ql_d  = {sum[0], ql_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ql_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      ql_q  <= opa_i;
      m_q   <= opb_i;
      cnt_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      ql_q  <= ql_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign acc_o  = acc_q;
  assign ql_o   = ql_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit beside the EX-stage ALU.
// Iterative MULT/DIV, single-cycle MTHI/MTLO, stall for MFHI/MFLO.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit MUL_ITER = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  md_state_t state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic dz_q, dz_d, div_q, div_d;

  logic is_mul, is_div, is_mt, sgn;
  logic sa, sb, iter, accept, last;
  logic [WIDTH-1:0] a_mag, b_mag, acc, ql;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [2*WIDTH-1:0] p_comb, p_fix;

  assign is_mul = (op == MULT) | (op == MULTU);
  assign is_div = (op == DIV) | (op == DIVU);
  assign is_mt  = (op == MTHI) | (op == MTLO);
  assign sgn    = (op == MULT) | (op == DIV);
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign iter   = is_div | (is_mul & MUL_ITER);

  assign accept = (state_q == IDLE) & start & ~flush
                & (is_mul | is_div | is_mt);

  assign a_mag = WIDTH'(abs_w(MAX_W'(a), sa));
  assign b_mag = WIDTH'(abs_w(MAX_W'(b), sb));

  // Sign-extended operands give the right low 2W bits either way
  assign p_comb = {{WIDTH{sa}}, a} * {{WIDTH{sb}}, b};

  assign p_fix = neg_q ? -{acc, ql} : {acc, ql};
  assign q_fix = dz_q ? '1 : (neg_q ? -ql : ql);
  assign r_fix = rneg_q ? -acc : acc;

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (reset),
    .load_i(accept & iter),
    .en_i  (state_q == RUN),
    .div_i (div_q),
    .opa_i (a_mag),
    .opb_i (b_mag),
    .acc_o (acc),
    .ql_o  (ql),
    .last_o(last)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op == MTHI: hi_d = a;
            op == MTLO: lo_d = a;
            iter: begin
              state_d = RUN;
              neg_d   = sa ^ sb;
              rneg_d  = sa;
              dz_d    = is_div & (b == '0);
              div_d   = is_div;
            end
            default: {hi_d, lo_d} = p_comb;
          endcase
        end
      end
      RUN: begin
        if (flush) state_d = IDLE;
        else if (last) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (div_q) begin
            hi_d = r_fix;
            lo_d = q_fix;
          end else begin
            {hi_d, lo_d} = p_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (rd_req | start);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit against an
// arithmetic reference model, checked every cycle plus literal checks.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic         flush  = 1'b0;
  logic         rd_req = 1'b0;
  md_op_t       op     = NONE;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic [W-1:0] hi, lo;
  logic         busy, stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]   m_hi   = '0;
  logic [W-1:0]   m_lo   = '0;
  logic           m_busy = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_res  = '0;

  muldiv_unit #(
    .WIDTH   (W),
    .MUL_ITER(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .rd_req(rd_req),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .stall (stall)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from plain arithmetic
  function automatic logic [63:0] ref_res(input md_op_t o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] r;
    longint sx, sy;
    int q, rm;
    r  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT:  r = sx * sy;
      MULTU: r = {32'd0, x} * {32'd0, y};
      DIVU: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      DIV: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = {32'h0, 32'h80000000};
        else begin
          q  = $signed(x) / $signed(y);
          rm = $signed(x) % $signed(y);
          r  = {rm, q};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reference model: result lands WIDTH+1 edges after acceptance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      if (flush) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
        m_busy <= 1'b0;
      end else m_left <= m_left - 1;
    end else if (start && !flush) begin
      case (op)
        MTHI: m_hi <= a;
        MTLO: m_lo <= a;
        MULT, MULTU, DIV, DIVU: begin
          m_res  <= ref_res(op, a, b);
          m_busy <= 1'b1;
          m_left <= W + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    cmp("hi", hi, m_hi);
    cmp("lo", lo, m_lo);
    cmp1("busy", busy, m_busy);
    cmp1("stall", stall, m_busy & (rd_req | start));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input md_op_t o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = NONE;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic run_iter(input md_op_t o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh,
                          input logic [W-1:0] el);
    int n;
    issue(o, x, y);
    cmp1({o.name(), "_busy"}, busy, 1'b1);
    wait_done(n);
    cmp({o.name(), "_lat"}, n, W + 1);
    cmp({o.name(), "_hi"}, hi, eh);
    cmp({o.name(), "_lo"}, lo, el);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) tick();
    cmp("rst_hi", hi, 32'h0);
    cmp("rst_lo", lo, 32'h0);
    cmp1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    issue(MTHI, 32'h12345678, 32'h0);
    cmp("mthi_hi", hi, 32'h12345678);
    cmp1("mthi_busy", busy, 1'b0);
    issue(MTLO, 32'h9ABCDEF0, 32'h0);
    cmp("mtlo_lo", lo, 32'h9ABCDEF0);
    cmp("mtlo_hi", hi, 32'h12345678);
    cmp1("mtlo_busy", busy, 1'b0);

    run_iter(MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_iter(MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    run_iter(DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_iter(DIVU,  32'h7, 32'h2, 32'h1, 32'h3);
    run_iter(DIVU,  32'h55, 32'h0, 32'h55, 32'hFFFFFFFF);
    run_iter(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_iter(DIV,   32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_iter(DIV,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    run_iter(DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hE);
    run_iter(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run_iter(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
    run_iter(DIVU,  32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);

    // MFHI waiting on a DIV, with a re-presented start mid-flight
    rd_req = 1'b1;
    issue(DIV, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 200) begin
      #1;
      cmp1("stall_busy", stall, 1'b1);
      tick();
      n++;
      if (n == 5) begin
        start = 1'b1;
        op    = MTHI;
        a     = 32'hDEADBEEF;
      end
      if (n == 8) begin
        start = 1'b0;
        op    = NONE;
      end
    end
    #1;
    cmp1("stall_idle", stall, 1'b0);
    cmp("stall_lat", n, W + 1);
    cmp("stall_hi", hi, 32'd2);
    cmp("stall_lo", lo, 32'd14);
    rd_req = 1'b0;
    tick();

    // flush with start in IDLE: nothing accepted
    start = 1'b1;
    op    = MTHI;
    a     = 32'h11111111;
    flush = 1'b1;
    tick();
    start = 1'b0;
    op    = NONE;
    flush = 1'b0;
    cmp("flush_idle_hi", hi, 32'd2);
    cmp1("flush_idle_busy", busy, 1'b0);

    // flush during RUN
    issue(MTHI, 32'hAAAA0000, 32'h0);
    issue(MTLO, 32'h0000BBBB, 32'h0);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp1("flush_run_busy", busy, 1'b0);
    cmp("flush_run_hi", hi, 32'hAAAA0000);
    cmp("flush_run_lo", lo, 32'h0000BBBB);
    repeat (40) tick();
    cmp("flush_run_hi2", hi, 32'hAAAA0000);

    // flush on the write-back cycle
    issue(MULTU, 32'h3, 32'h5);
    repeat (W) tick();
    cmp1("fix_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp1("flush_fix_busy", busy, 1'b0);
    cmp("flush_fix_lo", lo, 32'h0000BBBB);

    // reset in the middle of an operation
    issue(DIV, 32'd12345, 32'd67);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    cmp("rst_mid_hi", hi, 32'h0);
    cmp("rst_mid_lo", lo, 32'h0);
    cmp1("rst_mid_busy", busy, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    cmp1("rst_rel_busy", busy, 1'b0);
    run_iter(DIVU, 32'd12345, 32'd67, 32'd17, 32'd184);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core. It replaces the fixed single-cycle hienE/loenE register write path.
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle. It holds the HI/LO architectural registers.
- Exposes busy and stall so the hazard logic can freeze MFHI/MFLO until results are ready.
- Sits beside the ALU in the EX stage. Operands come from the forwarded srcA/srcB of stage E.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits; must be even and >= 4.
- MUL_ITER, 1, 1 = radix-2 shift-add multiply over WIDTH cycles; 0 = single-cycle combinational multiply.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request valid in stage E.
- op  in  3  muldiv_pkg::md_op_t operation code.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  cancel any in-flight operation.
- rd_req  in  1  MFHI/MFLO present in stage D.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  iterative operation in flight.
- stall  out  1  busy & (rd_req | start); pipeline must hold D/E.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: start accepted here only.
  - RUN: iterations in progress.
  - FIX: sign correction and HI/LO write.
- Acceptance:
  - A request is accepted at rising edge E0 when state=IDLE, start=1, flush=0 and op is not NONE.
  - If state is not IDLE, start is ignored; stall is asserted, so the pipeline re-presents the request.
- MTHI/MTLO: hi (or lo) <= a at E0. Always single-cycle; busy stays 0.
- MULT/MULTU with MUL_ITER=0: {hi,lo} <= 2*WIDTH-bit product at E0; busy stays 0.
- MULT/MULTU with MUL_ITER=1, and all DIV/DIVU:
  - E0: latch the operand magnitudes (signed ops take absolute values), record the result signs, and set busy=1.
  - RUN: WIDTH iterations, one per cycle, counter 0..WIDTH-1.
  - FIX: apply signs and write hi/lo.
  - Result is visible and busy=0 after edge E0+WIDTH+1.
- Multiply result: lo = low half of the product, hi = high half. Signed: two's-complement 2*WIDTH-bit product.
- Divide (restoring radix-2):
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (b=0):
  - Runs the full latency.
  - lo = all ones; hi = a (unsigned and signed alike).
- Signed overflow (a = most-negative value, b = -1): lo = most-negative value, hi = 0.
- flush:
  - In RUN or FIX, flush returns state to IDLE at the next edge and sets busy=0.
  - hi/lo keep their pre-operation values.
  - flush together with start in IDLE means no acceptance.
- Operands latched at E0; later changes on a/b have no effect.
- hi/lo never change except at an MTHI/MTLO edge, the FIX edge, a single-cycle multiply edge, or reset.
- Reset mid-operation: immediate return to the reset state; no partial result is written.
- stall is combinational. It is 0 whenever busy=0, so a same-cycle MFHI after a single-cycle op reads through the normal forward path.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_t enum (3 bits): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - md_state_t enum: IDLE, RUN, FIX.
  - Helper function abs_w for the operand magnitudes.
- One sub-module: md_iter_core. It holds the shared WIDTH-cycle shift datapath: the accumulator/remainder register, a mode select between add-shift and subtract-restore, and the counter.
- The top handles acceptance, sign fix-up, the HI/LO registers and stall.

Test Plan:
- Reset, then MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi=0x12345678 and lo=0x9ABCDEF0 one edge later each; busy never rises.
- MULT a=0xFFFFFFFE (-2), b=0x00000003, MUL_ITER=1 -> busy=1 for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> after 33 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x00000055, b=0 -> lo=0xFFFFFFFF, hi=0x00000055. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- rd_req=1 throughout a DIV -> stall=1 in every busy cycle, and 0 on the cycle busy falls. A second start while busy -> ignored, with stall=1.
- Preload hi=0xAAAA0000, lo=0x0000BBBB; start DIVU; assert flush at iteration 10 -> busy=0 next edge, hi/lo unchanged. Separately, drive reset=0 at iteration 5 -> hi=lo=0 immediately, busy=0.
